// File: rtl/ram_port_arbiter.sv
// Round-robin two-requester arbiter in front of a 1W/1R registered-read RAM.
// Define RAM_ARB_INIT_EN to compile in the post-reset memory clear sweep.
module ram_port_arbiter #(
   parameter int                 D_WIDTH    = 16,
   parameter int                 A_WIDTH    = 5,
   parameter logic [D_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               a_req,
   input  logic               a_we,
   input  logic [A_WIDTH-1:0] a_addr,
   input  logic [D_WIDTH-1:0] a_wdata,
   input  logic               b_req,
   input  logic               b_we,
   input  logic [A_WIDTH-1:0] b_addr,
   input  logic [D_WIDTH-1:0] b_wdata,
   output logic               a_gnt,
   output logic               b_gnt,
   output logic               a_rvalid,
   output logic               b_rvalid,
   output logic [D_WIDTH-1:0] a_rdata,
   output logic [D_WIDTH-1:0] b_rdata,
   output logic [A_WIDTH-1:0] ram_address_write,
   output logic [D_WIDTH-1:0] ram_data_write,
   output logic               ram_write_enable,
   output logic [A_WIDTH-1:0] ram_address_read,
   input  logic [D_WIDTH-1:0] ram_data_read,
   output logic               init_busy
);

   logic ptr_q, ptr_d;   // 0 favours A, 1 favours B
   logic rv_q, rv_d;
   logic own_q, own_d;   // owner of the read in flight: 0 = A, 1 = B
   logic serve;

`ifdef RAM_ARB_INIT_EN
   typedef enum logic {S_INIT, S_SERVE} state_t;
   localparam logic [A_WIDTH-1:0] CNT_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [A_WIDTH-1:0] CNT_LAST = {A_WIDTH{1'b1}};

   state_t             state_q, state_d;
   logic [A_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter parks on the last address so the sweep can never restart.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         if (cnt_q == CNT_LAST) state_d = S_SERVE;
         else                   cnt_d   = cnt_q + CNT_ONE;
      end
   end

   assign serve     = (state_q == S_SERVE);
   assign init_busy = ~serve;
`else
   assign serve     = 1'b1;
   assign init_busy = 1'b0;
`endif

   assign a_gnt = serve & a_req & (~b_req | ~ptr_q);
   assign b_gnt = serve & b_req & (~a_req |  ptr_q);

   assign ptr_d = (a_gnt | b_gnt) ? a_gnt : ptr_q;
   assign rv_d  = (a_gnt & ~a_we) | (b_gnt & ~b_we);
   assign own_d = b_gnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr_q <= 1'b0;
         rv_q  <= 1'b0;
         own_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         rv_q  <= rv_d;
         own_q <= own_d;
      end
   end

   always_comb begin
      ram_write_enable  = 1'b0;
      ram_address_write = a_addr;
      ram_data_write    = a_wdata;
      ram_address_read  = a_addr;
      if (b_gnt) begin
         ram_write_enable  = b_we;
         ram_address_write = b_addr;
         ram_data_write    = b_wdata;
         ram_address_read  = b_addr;
      end else if (a_gnt) begin
         ram_write_enable  = a_we;
      end
`ifdef RAM_ARB_INIT_EN
      if (init_busy) begin
         ram_write_enable  = 1'b1;
         ram_address_write = cnt_q;
         ram_data_write    = INIT_VALUE;
      end
`endif
   end

   assign a_rvalid = rv_q & ~own_q;
   assign b_rvalid = rv_q &  own_q;
   assign a_rdata  = ram_data_read;
   assign b_rdata  = ram_data_read;

endmodule
